// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue with branch redirect (optional FQ_BYPASS_EN empty-queue bypass)
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [7:0]  RESET_PC = 8'h00
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     jump,
  input  logic [7:0]               jump_target,
  output logic                     imem_req,
  output logic [7:0]               imem_addr,
  input  logic [7:0]               imem_rdata,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_instr,
  output logic [7:0]               out_pc,
  output logic                     jumped,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic {ST_RUN, ST_REDIRECT} state_t;

  state_t          state_q, state_d;
  logic [7:0]      fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [7:0]      inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            jumped_q, jumped_d;
  logic [7:0]      mem_pc_q [DEPTH];
  logic [7:0]      mem_pc_d [DEPTH];
  logic [7:0]      mem_instr_q [DEPTH];
  logic [7:0]      mem_instr_d [DEPTH];

  logic            head_pop;
  logic            returning;
  logic            bypass_valid;
  logic            bypass_take;
  logic            push;
  logic [CW:0]     pending;

  // Handshake decode, credit check and output muxing.
  always_comb begin
    head_pop  = (count_q != '0) && out_ready;
    returning = inflight_q && !jump;
`ifdef FQ_BYPASS_EN
    bypass_valid = returning && (count_q == '0);
`else
    bypass_valid = 1'b0;
`endif
    bypass_take = bypass_valid && out_ready;
    push        = returning && !bypass_take;
    // Entries after this edge, counting the word in flight; a same-cycle pop frees a credit.
    pending  = {1'b0, count_q} + (CW+1)'(inflight_q && !bypass_take) - (CW+1)'(head_pop);
    imem_req = !reset && (state_q == ST_RUN) && (pending < DEPTH_W);
    imem_addr = fetch_pc_q;
    out_valid = (count_q != '0) || bypass_valid;
    out_instr = bypass_valid ? imem_rdata    : mem_instr_q[rd_ptr_q];
    out_pc    = bypass_valid ? inflight_pc_q : mem_pc_q[rd_ptr_q];
    jumped    = jumped_q;
    occupancy = count_q;
  end

  // Next-state logic: a jump clears the queue and kills the in-flight word.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    jumped_d      = 1'b0;
    mem_pc_d      = mem_pc_q;
    mem_instr_d   = mem_instr_q;
    if (jump) begin
      state_d    = ST_REDIRECT;
      fetch_pc_d = jump_target;
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      jumped_d   = 1'b1;
    end else begin
      state_d    = ST_RUN;
      inflight_d = imem_req;
      if (imem_req) begin
        fetch_pc_d    = fetch_pc_q + 8'd1;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) begin
        mem_pc_d[wr_ptr_q]    = inflight_pc_q;
        mem_instr_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = wr_ptr_q + 1'b1;
      end
      if (head_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(head_pop);
    end
  end

  // State and storage registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 8'h00;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      jumped_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= 8'h00;
        mem_instr_q[i] <= 8'h00;
      end
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      jumped_q      <= jumped_d;
      mem_pc_q      <= mem_pc_d;
      mem_instr_q   <= mem_instr_d;
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch buffer between the instruction memory and the decode stage (mux_alpha).
- Keeps the 8-bit instruction stream flowing while decode is stalled.
- On a taken branch, redirects fetch to the branch target and discards stale words.
- Replaces direct PC-to-decode coupling; program_counter keeps only the architectural PC for the ALU jump path.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- RESET_PC, 8'h00, first fetch address after reset.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- jump  input  1  taken-branch redirect request from controler/alu.
- jump_target  input  8  redirect address; sampled when jump=1.
- imem_req  output  1  read strobe to instruction memory.
- imem_addr  output  8  read address; data returns exactly 1 cycle later.
- imem_rdata  input  8  instruction word for the request issued in the previous cycle.
- out_ready  input  1  decode can accept a word this cycle.
- out_valid  output  1  out_instr/out_pc hold a valid entry.
- out_instr  output  8  oldest queued instruction.
- out_pc  output  8  address of out_instr.
- jumped  output  1  one-cycle pulse; redirect accepted.
- occupancy  output  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (asynchronous, immediate):
  - fetch_pc=RESET_PC; queue empty; in-flight flag=0.
  - imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, jumped=0, occupancy=0.
- Storage:
  - Circular buffer of DEPTH entries, each {pc[7:0], instr[7:0]}.
  - Read and write pointers wrap modulo DEPTH.
- Fetch issue:
  - imem_req=1 when state==RUN and occupancy + inflight < DEPTH (credit check; the queue never overflows).
  - imem_addr=fetch_pc. On issue, fetch_pc<=fetch_pc+1, 8-bit wrap 8'hFF->8'h00.
  - inflight<=imem_req. The returning word is written the next cycle together with its captured address.
- Pop: when out_valid && out_ready, read pointer advances. Push and pop in the same cycle leave occupancy unchanged.
- Output: out_instr/out_pc show the head entry (registered storage, combinational read of head). They are held stable while out_valid && !out_ready.
- FSM states:
  - RUN: normal fetch.
  - REDIRECT: entered on jump=1 from any state.
    - The queue is cleared, the in-flight word is marked stale, fetch_pc<=jump_target, jumped=1 for that edge only.
    - imem_req=0 in REDIRECT; next state is RUN.
    - First target word: request in RUN (cycle +1), out_valid at cycle +3.
- Simultaneous events:
  - jump and pop in the same cycle: jump wins; the pop is irrelevant because the queue clears.
  - jump in the cycle a word returns: the word is dropped.
  - jump while in REDIRECT: re-latch the new target, pulse jumped again, stay in REDIRECT one more cycle.
  - reset overrides everything.
- Full: no imem_req until a pop frees a credit. The freed credit is usable the same cycle as the pop.
- Empty: out_valid=0; out_instr/out_pc hold their last values (don't-care).

Optional Feature:
- FQ_BYPASS_EN defined:
  - When the queue is empty, a word is returning, and no jump is present, the word drives out_valid/out_instr/out_pc combinationally that cycle.
  - If out_ready=1, the word is consumed without being written.
  - Minimum request-to-decode latency is 1 cycle.
- FQ_BYPASS_EN undefined: every word passes through storage; minimum latency is 2 cycles (request at N, out_valid at N+2).

Test Plan:
- Reset release, out_ready=1, imem returns mem[a]=a+8'h10 -> imem_addr 00,01,02...; out_pc 00,01,02 with out_instr 10,11,12; first out_valid 2 cycles after the first req (1 cycle with FQ_BYPASS_EN).
- out_ready=0 from reset, DEPTH=4 -> exactly 4 requests (addr 00..03), occupancy=4, imem_req=0 thereafter; raise out_ready for 1 cycle -> one pop and one new req at addr 04.
- Queue holding 00..02, jump=1, jump_target=8'h40, word for 03 returning that cycle -> jumped pulses 1 cycle; occupancy=0; word 03 never appears; next out_pc=40.
- Back-to-back jumps to 8'h40 then 8'h80 -> two jumped pulses; no 40 word is delivered; first output out_pc=80.
- RESET_PC=8'hFE, free-running fetch -> out_pc sequence FE,FF,00,01 (wrap).
- Assert reset mid-stream with the queue at 3 entries -> all outputs immediately return to reset values without a clock edge; fetch restarts at RESET_PC.
